// File: rtl/cim_pkg.sv
// Shared constants and types for the time-domain CIM PWM front end.
// PWM_SEQ_DOUBLE_BUFFER_EN (see pwm_frame_sequencer) does not affect this package.
package cim_pkg;

    localparam int PWM_PHASE_W  = 7;
    localparam int PWM_PERIOD   = 128;
    localparam int PWM_DUTY_MSB = 9;
    localparam int PWM_DUTY_LSB = 3;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        RUN
    } seq_state_e;

endpackage

// File: rtl/pwm_phase_counter.sv
// Free-running PWM phase counter; resets and counts in lockstep with the pwm row drivers.
// wrap is high during the last cycle of each period (phase == PWM_PERIOD-1).
module pwm_phase_counter
    import cim_pkg::*;
(
    input  logic                   clk_1Mhz,
    input  logic                   reset_n,
    output logic [PWM_PHASE_W-1:0] phase,
    output logic                   wrap
);

    logic [PWM_PHASE_W-1:0] phase_reg;

    always_ff @(posedge clk_1Mhz or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

    assign phase = phase_reg;
    assign wrap  = (phase_reg == PWM_PHASE_W'(PWM_PERIOD - 1));

endmodule

// File: rtl/pwm_frame_sequencer.sv
// Launches buffered input vectors onto the pwm row drivers at period boundaries and frames them.
// Define PWM_SEQ_DOUBLE_BUFFER_EN to accept the next vector while a frame is running.
module pwm_frame_sequencer
    import cim_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int ROWS  = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk_1Mhz,
    input  logic                    reset_n,
    input  logic                    run_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*WIDTH-1:0]   in_words,
    output logic [ROWS*WIDTH-1:0]   word_out,
    output logic                    frame_start,
    output logic                    sample_strobe,
    output logic                    busy,
    output logic [CNT_W-1:0]        frames_done
);

    logic [PWM_PHASE_W-1:0] phase;
    logic                   wrap;
    logic                   unused_phase;

    seq_state_e             state_reg, state_next;
    logic                   buf_full_reg, buf_full_next;
    logic                   frame_start_reg, frame_start_next;
    logic                   sample_strobe_reg, sample_strobe_next;
    logic [CNT_W-1:0]       frames_done_reg, frames_done_next;

    logic                   frame_active;
    logic                   transfer;
    logic                   launch;

    pwm_phase_counter u_phase (
        .clk_1Mhz (clk_1Mhz),
        .reset_n  (reset_n),
        .phase    (phase),
        .wrap     (wrap)
    );

    // Only the wrap flag matters here; the raw phase is for the drivers alongside.
    assign unused_phase = ^phase;

    assign frame_active = (state_reg == RUN);
    assign transfer     = in_valid && in_ready;
    assign launch       = wrap && buf_full_reg && run_en;
    assign busy         = frame_active || buf_full_reg;

`ifdef PWM_SEQ_DOUBLE_BUFFER_EN
    assign in_ready = !buf_full_reg;
`else
    assign in_ready = !buf_full_reg && !frame_active;
`endif

    always_ff @(posedge clk_1Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            buf_full_reg      <= 1'b0;
            frame_start_reg   <= 1'b0;
            sample_strobe_reg <= 1'b0;
            frames_done_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            buf_full_reg      <= buf_full_next;
            frame_start_reg   <= frame_start_next;
            sample_strobe_reg <= sample_strobe_next;
            frames_done_reg   <= frames_done_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        buf_full_next      = buf_full_reg;
        frame_start_next   = 1'b0;
        sample_strobe_next = 1'b0;
        frames_done_next   = frames_done_reg;

        // A transfer on the wrap edge lands in the buffer after the launch decision,
        // so it waits a whole period.
        if (transfer) begin
            buf_full_next = 1'b1;
        end

        if (wrap) begin
            frame_start_next   = launch;
            sample_strobe_next = frame_active;
            if (frame_active) begin
                frames_done_next = frames_done_reg + 1'b1;
            end
            if (launch) begin
                buf_full_next = 1'b0;
                state_next    = RUN;
            end else if (buf_full_next) begin
                state_next    = PENDING;
            end else begin
                state_next    = IDLE;
            end
        end else if (transfer && (state_reg == IDLE)) begin
            state_next = PENDING;
        end
    end

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [WIDTH-1:0] bufq_reg;
            logic [WIDTH-1:0] word_reg;

            always_ff @(posedge clk_1Mhz or negedge reset_n) begin
                if (!reset_n) begin
                    bufq_reg <= '0;
                    word_reg <= '0;
                end else begin
                    if (transfer) begin
                        bufq_reg <= in_words[gi*WIDTH +: WIDTH];
                    end
                    if (wrap) begin
                        word_reg <= launch ? bufq_reg : '0;
                    end
                end
            end

            assign word_out[gi*WIDTH +: WIDTH] = word_reg;
        end
    endgenerate

    assign frame_start   = frame_start_reg;
    assign sample_strobe = sample_strobe_reg;
    assign frames_done   = frames_done_reg;

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Self-checking bench for pwm_frame_sequencer against a cycle-indexed frame model.
// Works with PWM_SEQ_DOUBLE_BUFFER_EN defined or undefined.
module tb_pwm_frame_sequencer;

    localparam int WIDTH = 10;
    localparam int ROWS  = 8;
    localparam int CNT_W = 4;
    localparam int VW    = ROWS * WIDTH;

`ifdef PWM_SEQ_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic             clk_1Mhz = 1'b0;
    logic             reset_n  = 1'b0;
    logic             run_en   = 1'b1;
    logic             in_valid = 1'b0;
    logic [VW-1:0]    in_words = '0;
    logic             in_ready;
    logic [VW-1:0]    word_out;
    logic             frame_start;
    logic             sample_strobe;
    logic             busy;
    logic [CNT_W-1:0] frames_done;

    pwm_frame_sequencer #(.WIDTH(WIDTH), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk_1Mhz      (clk_1Mhz),
        .reset_n       (reset_n),
        .run_en        (run_en),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_words      (in_words),
        .word_out      (word_out),
        .frame_start   (frame_start),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .frames_done   (frames_done)
    );

    always #5 clk_1Mhz = ~clk_1Mhz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Model: t counts cycles since reset release; phase = t % 128.
    // A frame launched for cycle L is active for L..L+127 and strobes at L+128.
    int            t;
    logic [VW-1:0] pend_q[$];
    int            launches[$];
    logic [VW-1:0] m_word;
    int            fs_log[$];
    int            ss_log[$];
    logic          exp_ready;
    logic          xfer;

    function automatic bit m_active(input int tt);
        foreach (launches[i])
            if (launches[i] <= tt && tt <= launches[i] + 127) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_fs(input int tt);
        foreach (launches[i]) if (launches[i] == tt) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ss(input int tt);
        foreach (launches[i]) if (launches[i] + 128 == tt) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_done(input int tt);
        int c = 0;
        foreach (launches[i]) if (launches[i] + 128 <= tt) c++;
        return c % (1 << CNT_W);
    endfunction

    function automatic int fs_at(input int i);
        if (i < fs_log.size()) return fs_log[i];
        return -1;
    endfunction

    function automatic int ss_at(input int i);
        if (i < ss_log.size()) return ss_log[i];
        return -1;
    endfunction

    always @(negedge clk_1Mhz) begin
        if (!reset_n) begin
            t = 0;
            pend_q.delete();
            launches.delete();
            fs_log.delete();
            ss_log.delete();
            m_word = '0;
            check("rst_word_out", word_out, '0);
            check("rst_in_ready", VW'(in_ready), VW'(1));
            check("rst_frame_start", VW'(frame_start), '0);
            check("rst_sample_strobe", VW'(sample_strobe), '0);
            check("rst_busy", VW'(busy), '0);
            check("rst_frames_done", VW'(frames_done), '0);
        end else begin
            exp_ready = (pend_q.size() == 0) && (DB || !m_active(t));
            check("in_ready", VW'(in_ready), VW'(exp_ready));
            check("busy", VW'(busy), VW'(m_active(t) || pend_q.size() != 0));
            check("frame_start", VW'(frame_start), VW'(m_fs(t)));
            check("sample_strobe", VW'(sample_strobe), VW'(m_ss(t)));
            check("frames_done", VW'(frames_done), VW'(m_done(t)));
            check("word_out", word_out, m_word);
            if (frame_start) fs_log.push_back(t);
            if (sample_strobe) ss_log.push_back(t);
            xfer = in_valid && exp_ready;
            if (t % 128 == 127) begin
                if (pend_q.size() > 0 && run_en) begin
                    launches.push_back(t + 1);
                    m_word = pend_q.pop_front();
                end else begin
                    m_word = '0;
                end
            end
            if (xfer) pend_q.push_back(in_words);
            t++;
        end
    end

    int cur;

    task automatic tick();
        @(posedge clk_1Mhz);
        #1;
        cur++;
    endtask

    task automatic goto(input int n);
        while (cur < n) tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        run_en   = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk_1Mhz);
        #1;
        reset_n = 1'b1;
        cur     = 0;
    endtask

    task automatic send(input logic [VW-1:0] vec);
        int n = 0;
        in_words = vec;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        check("send_ready", VW'(in_ready), VW'(1));
        $display("transfer at cycle %0d: %h", cur, vec);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec(input bit zero_duty);
        logic [VW-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v[r*WIDTH +: WIDTH] = WIDTH'($urandom);
            if (zero_duty) v[r*WIDTH + 3 +: 7] = 7'd0;
        end
        return v;
    endfunction

    logic [VW-1:0] vec_a;

    initial begin
        // Reset state
        do_reset();

        // A: transfer at cycle 5, row0 = 10'h3F8
        vec_a = rand_vec(1'b0);
        vec_a[9:0] = 10'h3F8;
        goto(5);
        send(vec_a);
        goto(127);
        @(negedge clk_1Mhz);
        check("A_word_c127", word_out, '0);
        check("A_fs_c127", VW'(frame_start), '0);
        goto(128);
        @(negedge clk_1Mhz);
        check("A_word_c128", word_out, vec_a);
        check("A_fs_c128", VW'(frame_start), VW'(1));
        goto(256);
        @(negedge clk_1Mhz);
        check("A_ss_c256", VW'(sample_strobe), VW'(1));
        check("A_done_c256", VW'(frames_done), VW'(1));
        goto(260);
        check("A_fs_cycle", VW'(fs_at(0)), VW'(128));
        check("A_ss_cycle", VW'(ss_at(0)), VW'(256));

        // B: transfer on the first phase==127 edge waits a full period
        do_reset();
        goto(127);
        send(rand_vec(1'b0));
        goto(390);
        check("B_fs_count", VW'(fs_log.size()), VW'(1));
        check("B_fs_cycle", VW'(fs_at(0)), VW'(256));
        check("B_ss_cycle", VW'(ss_at(0)), VW'(384));

        // C: three streamed vectors, the second with zero words
        do_reset();
        send(rand_vec(1'b0));
        send('0);
        send(rand_vec(1'b1));
        goto(800);
        check("C_fs0", VW'(fs_at(0)), VW'(128));
        check("C_fs1", VW'(fs_at(1)), VW'(DB ? 256 : 384));
        check("C_fs2", VW'(fs_at(2)), VW'(DB ? 384 : 640));
        check("C_done", VW'(frames_done), VW'(3));

        // D: run_en low holds the pending vector
        do_reset();
        run_en = 1'b0;
        goto(3);
        send(rand_vec(1'b0));
        goto(130);
        @(negedge clk_1Mhz);
        check("D_word_held", word_out, '0);
        check("D_busy_held", VW'(busy), VW'(1));
        check("D_no_fs", VW'(fs_log.size()), '0);
        goto(200);
        run_en = 1'b1;
        goto(260);
        check("D_fs_cycle", VW'(fs_at(0)), VW'(256));

        // E: reset mid-frame aborts the frame and drops the pending vector
        do_reset();
        send(rand_vec(1'b0));
        if (DB) send(rand_vec(1'b0));
        goto(200);
        reset_n = 1'b0;
        #1;
        check("E_busy_rst", VW'(busy), '0);
        check("E_word_rst", word_out, '0);
        check("E_ready_rst", VW'(in_ready), VW'(1));
        @(posedge clk_1Mhz);
        #1;
        reset_n = 1'b1;
        cur     = 0;
        goto(400);
        check("E_no_ss", VW'(ss_log.size()), '0);
        check("E_no_fs", VW'(fs_log.size()), '0);
        check("E_done", VW'(frames_done), '0);

        // F: sixteen frames wrap the 4-bit counter back to 0
        do_reset();
        for (int i = 0; i < 16; i++) send(rand_vec(i % 4 == 3));
        begin
            int n = 0;
            while (ss_log.size() < 16 && n < 600) begin
                tick();
                n++;
            end
        end
        tick();
        check("F_ss_count", VW'(ss_log.size()), VW'(16));
        check("F_done_wrap", VW'(frames_done), '0);

        // R: randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_words = rand_vec($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) run_en = ~run_en;
            tick();
        end
        in_valid = 1'b0;
        run_en   = 1'b1;
        goto(cur + 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
